// File: rtl/jtdd_rom_arb.sv
// Graphics ROM arbiter: char, scroll and object requesters each keep a one-word cache
// and share one SDRAM read port. Misses are served round-robin over req/ack/data_rdy.
module jtdd_rom_arb #(
  parameter logic [21:0] CHAR_OFFSET = 22'h00_0000,
  parameter logic [21:0] SCR_OFFSET  = 22'h00_8000,
  parameter logic [21:0] OBJ_OFFSET  = 22'h04_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] char_addr,
  input  logic        char_cs,
  output logic        char_ok,
  output logic [15:0] char_data,
  input  logic [16:0] scr_addr,
  input  logic        scr_cs,
  output logic        scr_ok,
  output logic [15:0] scr_data,
  input  logic [17:0] obj_addr,
  input  logic        obj_cs,
  output logic        obj_ok,
  output logic [15:0] obj_data,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        data_rdy,
  input  logic [15:0] data_read
);

  typedef enum logic [1:0] {StIdle, StWaitAck, StWaitData} state_e;

  state_e      state_q, state_d;
  logic [17:0] cached_addr_q [3];
  logic [15:0] data_q [3];
  logic [2:0]  valid_q;
  logic        inflight_q, inflight_d;
  logic [1:0]  cur_slot_q, cur_slot_d;
  logic [17:0] cur_addr_q, cur_addr_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic        sdram_req_q, sdram_req_d;
  logic [21:0] sdram_addr_q, sdram_addr_d;
  logic        store;

  logic [2:0]  cs_v, busy, hit, pending;
  logic [3:0]  pending_x;
  logic [17:0] addr_v [3];

  logic [1:0]  cand1, cand2, grant_slot;
  logic        grant_valid;
  logic [17:0] grant_addr;
  logic [21:0] grant_off;

  function automatic logic [1:0] next_slot(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  assign cs_v      = {obj_cs, scr_cs, char_cs};
  assign addr_v[0] = {3'b000, char_addr};
  assign addr_v[1] = {1'b0, scr_addr};
  assign addr_v[2] = obj_addr;

  // The slot being fetched never reports a hit, even if its old cache word matches.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      busy[i]    = inflight_q && (cur_slot_q == 2'(i));
      hit[i]     = cs_v[i] && valid_q[i] && (cached_addr_q[i] == addr_v[i]) && !busy[i];
      pending[i] = cs_v[i] && !hit[i] && !busy[i];
    end
  end

  assign pending_x = {1'b0, pending};
  assign cand1     = next_slot(rr_ptr_q);
  assign cand2     = next_slot(cand1);

  always_comb begin
    grant_valid = 1'b1;
    grant_slot  = rr_ptr_q;
    if (pending_x[rr_ptr_q]) begin
      grant_slot = rr_ptr_q;
    end else if (pending_x[cand1]) begin
      grant_slot = cand1;
    end else if (pending_x[cand2]) begin
      grant_slot = cand2;
    end else begin
      grant_valid = 1'b0;
    end
  end

  always_comb begin
    grant_addr = addr_v[2];
    grant_off  = OBJ_OFFSET;
    case (grant_slot)
      2'd0: begin
        grant_addr = addr_v[0];
        grant_off  = CHAR_OFFSET;
      end
      2'd1: begin
        grant_addr = addr_v[1];
        grant_off  = SCR_OFFSET;
      end
      default: begin
        grant_addr = addr_v[2];
        grant_off  = OBJ_OFFSET;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    inflight_d   = inflight_q;
    cur_slot_d   = cur_slot_q;
    cur_addr_d   = cur_addr_q;
    rr_ptr_d     = rr_ptr_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    store        = 1'b0;
    case (state_q)
      StIdle: begin
        sdram_req_d = 1'b0;
        if (grant_valid) begin
          cur_slot_d   = grant_slot;
          cur_addr_d   = grant_addr;
          sdram_addr_d = grant_off + {4'b0000, grant_addr};
          sdram_req_d  = 1'b1;
          inflight_d   = 1'b1;
          state_d      = StWaitAck;
        end
      end
      StWaitAck: begin
        if (sdram_ack) begin
          sdram_req_d = 1'b0;
          // Controllers with a short path may return data together with the ack.
          if (data_rdy) begin
            store      = 1'b1;
            inflight_d = 1'b0;
            rr_ptr_d   = next_slot(cur_slot_q);
            state_d    = StIdle;
          end else begin
            state_d = StWaitData;
          end
        end
      end
      StWaitData: begin
        if (data_rdy) begin
          store      = 1'b1;
          inflight_d = 1'b0;
          rr_ptr_d   = next_slot(cur_slot_q);
          state_d    = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      inflight_q   <= 1'b0;
      cur_slot_q   <= 2'd0;
      cur_addr_q   <= '0;
      rr_ptr_q     <= 2'd0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      valid_q      <= '0;
      for (int i = 0; i < 3; i++) begin
        cached_addr_q[i] <= '0;
        data_q[i]        <= '0;
      end
    end else begin
      state_q      <= state_d;
      inflight_q   <= inflight_d;
      cur_slot_q   <= cur_slot_d;
      cur_addr_q   <= cur_addr_d;
      rr_ptr_q     <= rr_ptr_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      for (int i = 0; i < 3; i++) begin
        if (store && (cur_slot_q == 2'(i))) begin
          cached_addr_q[i] <= cur_addr_q;
          data_q[i]        <= data_read;
          valid_q[i]       <= 1'b1;
        end
      end
    end
  end

  assign char_ok    = hit[0];
  assign scr_ok     = hit[1];
  assign obj_ok     = hit[2];
  assign char_data  = data_q[0];
  assign scr_data   = data_q[1];
  assign obj_data   = data_q[2];
  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;

endmodule

// File: tb/tb_jtdd_rom_arb.sv
// Bench for jtdd_rom_arb: directed scenarios plus randomized traffic against a cache model.
module tb_jtdd_rom_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [14:0] char_addr;
  logic        char_cs;
  logic        char_ok;
  logic [15:0] char_data;
  logic [16:0] scr_addr;
  logic        scr_cs;
  logic        scr_ok;
  logic [15:0] scr_data;
  logic [17:0] obj_addr;
  logic        obj_cs;
  logic        obj_ok;
  logic [15:0] obj_data;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        data_rdy;
  logic [15:0] data_read;

  logic        w_obj_cs;
  logic [17:0] w_obj_addr;
  logic        w_char_ok, w_scr_ok, w_obj_ok, w_sdram_req;
  logic [15:0] w_char_data, w_scr_data, w_obj_data;
  logic [21:0] w_sdram_addr;

  int total = 0;
  int bad   = 0;

  jtdd_rom_arb dut (
    .clk(clk), .rst(rst),
    .char_addr(char_addr), .char_cs(char_cs), .char_ok(char_ok), .char_data(char_data),
    .scr_addr(scr_addr), .scr_cs(scr_cs), .scr_ok(scr_ok), .scr_data(scr_data),
    .obj_addr(obj_addr), .obj_cs(obj_cs), .obj_ok(obj_ok), .obj_data(obj_data),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .data_read(data_read)
  );

  jtdd_rom_arb #(.OBJ_OFFSET(22'h3F_FFF0)) dut_w (
    .clk(clk), .rst(rst),
    .char_addr(15'd0), .char_cs(1'b0), .char_ok(w_char_ok), .char_data(w_char_data),
    .scr_addr(17'd0), .scr_cs(1'b0), .scr_ok(w_scr_ok), .scr_data(w_scr_data),
    .obj_addr(w_obj_addr), .obj_cs(w_obj_cs), .obj_ok(w_obj_ok), .obj_data(w_obj_data),
    .sdram_req(w_sdram_req), .sdram_addr(w_sdram_addr), .sdram_ack(1'b0),
    .data_rdy(1'b0), .data_read(16'd0)
  );

  // Reference model: one cached word per requester and the slot after the last one served.
  bit          m_valid [3];
  logic [17:0] m_addr  [3];
  logic [15:0] m_data  [3];
  int          m_rr;

  function automatic logic [17:0] in_addr(int s);
    case (s)
      0:       return {3'b000, char_addr};
      1:       return {1'b0, scr_addr};
      default: return obj_addr;
    endcase
  endfunction

  function automatic bit in_cs(int s);
    case (s)
      0:       return char_cs;
      1:       return scr_cs;
      default: return obj_cs;
    endcase
  endfunction

  function automatic int unsigned model_off(int s);
    case (s)
      0:       return 32'h0000_0000;
      1:       return 32'h0000_8000;
      default: return 32'h0004_0000;
    endcase
  endfunction

  function automatic bit model_ok(int s);
    return in_cs(s) && m_valid[s] && (m_addr[s] == in_addr(s));
  endfunction

  function automatic int model_pick();
    for (int k = 0; k < 3; k++) begin
      int s;
      s = (m_rr + k) % 3;
      if (in_cs(s) && !model_ok(s)) return s;
    end
    return -1;
  endfunction

  function automatic logic [21:0] model_sdram(int s);
    int unsigned v;
    v = (model_off(s) + 32'(in_addr(s))) % 32'h0040_0000;
    return 22'(v);
  endfunction

  function automatic logic slot_ok(int s);
    case (s)
      0:       return char_ok;
      1:       return scr_ok;
      default: return obj_ok;
    endcase
  endfunction

  function automatic logic [15:0] slot_data(int s);
    case (s)
      0:       return char_data;
      1:       return scr_data;
      default: return obj_data;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 1'b0;
      m_addr[i]  = '0;
      m_data[i]  = '0;
    end
    m_rr = 0;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    char_cs   = 1'b0;
    scr_cs    = 1'b0;
    obj_cs    = 1'b0;
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Acts as the SDRAM controller for one transaction; reports what it observed.
  task automatic serve(input int ack_dly, input int data_dly, input logic [15:0] d,
                       output int lat, output logic [21:0] seen_addr, output logic busy_ok);
    int s;
    int n;
    s       = model_pick();
    n       = 0;
    busy_ok = 1'b0;
    while (sdram_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    seen_addr = sdram_addr;
    lat       = (sdram_req === 1'b1) ? n : -1;
    if (lat < 0) return;
    repeat (ack_dly) @(negedge clk);
    busy_ok   = (s >= 0) ? slot_ok(s) : 1'b0;
    sdram_ack = 1'b1;
    if (data_dly == 0) begin
      data_rdy  = 1'b1;
      data_read = d;
    end
    @(negedge clk);
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    if (data_dly > 0) begin
      repeat (data_dly - 1) @(negedge clk);
      data_rdy  = 1'b1;
      data_read = d;
      @(negedge clk);
      data_rdy = 1'b0;
    end
    if (s >= 0) begin
      m_valid[s] = 1'b1;
      m_addr[s]  = in_addr(s);
      m_data[s]  = d;
      m_rr       = (s + 1) % 3;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    char_cs   = 1'b1;
    scr_cs    = 1'b1;
    obj_cs    = 1'b1;
    char_addr = '0;
    scr_addr  = '0;
    obj_addr  = '0;
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    data_read = '0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (sdram_req !== 1'b0) begin
      bad++; $display("FAIL reset_req: got %b want 0", sdram_req);
    end
    total++;
    if (sdram_addr !== 22'h0) begin
      bad++; $display("FAIL reset_addr: got %h want 000000", sdram_addr);
    end
    for (int s = 0; s < 3; s++) begin
      total++;
      if (slot_ok(s) !== 1'b0) begin
        bad++; $display("FAIL reset_ok slot%0d: got %b want 0", s, slot_ok(s));
      end
      total++;
      if (slot_data(s) !== 16'h0) begin
        bad++; $display("FAIL reset_data slot%0d: got %h want 0000", s, slot_data(s));
      end
    end
    @(negedge clk);
    apply_reset();
  endtask

  task automatic test_single_miss();
    int lat;
    logic [21:0] a;
    logic bo;
    apply_reset();
    char_cs   = 1'b1;
    char_addr = 15'h0123;
    #1;
    total++;
    if (char_ok !== 1'b0) begin
      bad++; $display("FAIL miss_ok_low: got %b want 0", char_ok);
    end
    serve(3, 2, 16'hBEEF, lat, a, bo);
    total++;
    if (lat !== 1) begin
      bad++; $display("FAIL miss_latency: got %0d want 1", lat);
    end
    total++;
    if (a !== 22'h000123) begin
      bad++; $display("FAIL miss_addr: got %h want 000123", a);
    end
    total++;
    if (bo !== 1'b0) begin
      bad++; $display("FAIL miss_ok_inflight: got %b want 0", bo);
    end
    #1;
    total++;
    if (char_ok !== 1'b1 || char_data !== 16'hBEEF) begin
      bad++; $display("FAIL miss_hit: got ok=%b data=%h want ok=1 data=beef", char_ok, char_data);
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      total++;
      if (sdram_req !== 1'b0 || char_ok !== 1'b1) begin
        bad++; $display("FAIL hit_hold: got req=%b ok=%b want req=0 ok=1", sdram_req, char_ok);
      end
    end
    char_cs = 1'b0;
  endtask

  task automatic test_round_robin();
    int lat;
    logic [21:0] a;
    logic bo;
    logic [21:0] want [4];
    want[0] = 22'h000001;
    want[1] = 22'h008002;
    want[2] = 22'h040010;
    want[3] = 22'h000005;
    apply_reset();
    char_cs   = 1'b1;
    scr_cs    = 1'b1;
    obj_cs    = 1'b1;
    char_addr = 15'h0001;
    scr_addr  = 17'h00002;
    obj_addr  = 18'h00010;
    for (int t = 0; t < 4; t++) begin
      if (t == 2) char_addr = 15'h0005;
      serve(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 16'(16'h1000 + t), lat, a, bo);
      total++;
      if (lat !== 1 || a !== want[t]) begin
        bad++; $display("FAIL rr_order%0d: got lat=%0d addr=%h want lat=1 addr=%h", t, lat, a, want[t]);
      end
    end
    #1;
    total++;
    if (char_ok !== 1'b1 || obj_ok !== 1'b1 || scr_ok !== 1'b1) begin
      bad++; $display("FAIL rr_all_hit: got %b%b%b want 111", char_ok, scr_ok, obj_ok);
    end
    char_cs = 1'b0;
    scr_cs  = 1'b0;
    obj_cs  = 1'b0;
  endtask

  task automatic test_addr_change();
    int n;
    int lat;
    logic [21:0] a;
    logic bo;
    apply_reset();
    obj_cs   = 1'b1;
    obj_addr = 18'h00010;
    n = 0;
    while (sdram_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h040010) begin
      bad++; $display("FAIL chg_first_req: got req=%b addr=%h want 1 040010", sdram_req, sdram_addr);
    end
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    obj_addr  = 18'h00011;
    @(negedge clk);
    data_rdy  = 1'b1;
    data_read = 16'h1111;
    @(negedge clk);
    data_rdy = 1'b0;
    #1;
    total++;
    if (obj_ok !== 1'b0 || obj_data !== 16'h1111) begin
      bad++; $display("FAIL chg_stale: got ok=%b data=%h want ok=0 data=1111", obj_ok, obj_data);
    end
    m_valid[2] = 1'b1;
    m_addr[2]  = 18'h00010;
    m_data[2]  = 16'h1111;
    m_rr       = 0;
    serve(1, 1, 16'h2222, lat, a, bo);
    total++;
    if (lat !== 1 || a !== 22'h040011) begin
      bad++; $display("FAIL chg_second_req: got lat=%0d addr=%h want 1 040011", lat, a);
    end
    total++;
    if (bo !== 1'b0) begin
      bad++; $display("FAIL chg_ok_inflight: got %b want 0", bo);
    end
    #1;
    total++;
    if (obj_ok !== 1'b1 || obj_data !== 16'h2222) begin
      bad++; $display("FAIL chg_hit: got ok=%b data=%h want ok=1 data=2222", obj_ok, obj_data);
    end
    obj_cs = 1'b0;
  endtask

  task automatic test_same_cycle();
    int lat;
    logic [21:0] a;
    logic bo;
    apply_reset();
    scr_cs   = 1'b1;
    scr_addr = 17'h1_2345;
    serve(1, 0, 16'h5A5A, lat, a, bo);
    total++;
    if (a !== 22'h01A345) begin
      bad++; $display("FAIL same_addr: got %h want 01a345", a);
    end
    #1;
    total++;
    if (scr_ok !== 1'b1 || scr_data !== 16'h5A5A || sdram_req !== 1'b0) begin
      bad++; $display("FAIL same_store: got ok=%b data=%h req=%b want 1 5a5a 0", scr_ok, scr_data,
                      sdram_req);
    end
    scr_addr = 17'h1_2346;
    serve(0, 1, 16'hA5A5, lat, a, bo);
    total++;
    if (lat !== 1 || a !== 22'h01A346) begin
      bad++; $display("FAIL same_idle_next: got lat=%0d addr=%h want 1 01a346", lat, a);
    end
    scr_cs = 1'b0;
  endtask

  task automatic test_reset_midflight();
    int n;
    int lat;
    logic [21:0] a;
    logic bo;
    apply_reset();
    char_cs   = 1'b1;
    char_addr = 15'h0042;
    n = 0;
    while (sdram_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    char_cs = 1'b0;
    model_reset();
    #1;
    total++;
    if (sdram_req !== 1'b0 || char_ok !== 1'b0 || scr_ok !== 1'b0 || obj_ok !== 1'b0) begin
      bad++; $display("FAIL rstmid_clear: got req=%b ok=%b%b%b want 0 000", sdram_req, char_ok,
                      scr_ok, obj_ok);
    end
    data_rdy  = 1'b1;
    data_read = 16'hABCD;
    @(negedge clk);
    data_rdy = 1'b0;
    char_cs  = 1'b1;
    #1;
    total++;
    if (char_ok !== 1'b0 || char_data !== 16'h0000) begin
      bad++; $display("FAIL rstmid_late_data: got ok=%b data=%h want 0 0000", char_ok, char_data);
    end
    serve(0, 1, 16'h4242, lat, a, bo);
    total++;
    if (lat !== 1 || a !== 22'h000042) begin
      bad++; $display("FAIL rstmid_reissue: got lat=%0d addr=%h want 1 000042", lat, a);
    end
    char_cs = 1'b0;
  endtask

  task automatic test_spurious();
    int lat;
    logic [21:0] a;
    logic bo;
    apply_reset();
    sdram_ack = 1'b1;
    data_rdy  = 1'b1;
    data_read = 16'hDEAD;
    @(negedge clk);
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    char_cs   = 1'b1;
    char_addr = 15'h0000;
    #1;
    total++;
    if (sdram_req !== 1'b0 || char_ok !== 1'b0 || char_data !== 16'h0) begin
      bad++; $display("FAIL spurious: got req=%b ok=%b data=%h want 0 0 0000", sdram_req, char_ok,
                      char_data);
    end
    serve(2, 2, 16'h0F0F, lat, a, bo);
    total++;
    if (lat !== 1 || a !== 22'h000000) begin
      bad++; $display("FAIL spurious_then_req: got lat=%0d addr=%h want 1 000000", lat, a);
    end
    char_cs = 1'b0;
  endtask

  task automatic test_random();
    int lat;
    logic [21:0] a;
    logic [21:0] want;
    logic bo;
    int s;
    apply_reset();
    for (int it = 0; it < 40; it++) begin
      char_cs   = ($urandom_range(0, 3) != 0);
      scr_cs    = ($urandom_range(0, 3) != 0);
      obj_cs    = ($urandom_range(0, 3) != 0);
      char_addr = 15'($urandom_range(0, 2));
      scr_addr  = 17'h1_FFF0 + 17'($urandom_range(0, 1));
      obj_addr  = 18'h3_FFFE + 18'($urandom_range(0, 1));
      #1;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (slot_ok(k) !== model_ok(k) || slot_data(k) !== m_data[k]) begin
          bad++; $display("FAIL rand_pre it%0d slot%0d: got ok=%b data=%h want ok=%b data=%h", it, k,
                          slot_ok(k), slot_data(k), model_ok(k), m_data[k]);
        end
      end
      for (int t = 0; t < 4 && model_pick() >= 0; t++) begin
        s    = model_pick();
        want = model_sdram(s);
        serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 16'($urandom), lat, a, bo);
        total++;
        if (lat !== 1 || a !== want || bo !== 1'b0) begin
          bad++; $display("FAIL rand_req it%0d: got lat=%0d addr=%h okbusy=%b want 1 %h 0", it, lat,
                          a, bo, want);
        end
      end
      #1;
      total++;
      if (sdram_req !== 1'b0) begin
        bad++; $display("FAIL rand_quiet it%0d: got req=%b want 0", it, sdram_req);
      end
      for (int k = 0; k < 3; k++) begin
        total++;
        if (slot_ok(k) !== model_ok(k) || slot_data(k) !== m_data[k]) begin
          bad++; $display("FAIL rand_post it%0d slot%0d: got ok=%b data=%h want ok=%b data=%h", it, k,
                          slot_ok(k), slot_data(k), model_ok(k), m_data[k]);
        end
      end
      @(negedge clk);
    end
    char_cs = 1'b0;
    scr_cs  = 1'b0;
    obj_cs  = 1'b0;
  endtask

  task automatic test_offset_wrap();
    w_obj_cs   = 1'b1;
    w_obj_addr = 18'h00020;
    @(negedge clk);
    #1;
    total++;
    if (w_sdram_req !== 1'b1 || w_sdram_addr !== 22'h000010) begin
      bad++; $display("FAIL wrap_addr: got req=%b addr=%h want 1 000010", w_sdram_req, w_sdram_addr);
    end
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (w_sdram_req !== 1'b1 || w_sdram_addr !== 22'h000010) begin
      bad++; $display("FAIL wrap_hold: got req=%b addr=%h want 1 000010", w_sdram_req, w_sdram_addr);
    end
  endtask

  initial begin
    w_obj_cs   = 1'b0;
    w_obj_addr = '0;
    data_read  = '0;
    @(negedge clk);
    test_reset();
    test_single_miss();
    test_round_robin();
    test_addr_change();
    test_same_cycle();
    test_reset_midflight();
    test_spurious();
    test_random();
    test_offset_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

endmodule
